// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register feeding the register file write port
module mem_wb_stage #(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 m_valid,
  input  logic                 m_reg_write,
  input  logic [4:0]           m_rd,
  input  logic [1:0]           m_wb_sel,
  input  logic [2:0]           m_funct3,
  input  logic [31:0]          m_alu_result,
  input  logic [31:0]          m_mem_rdata,
  input  logic [31:0]          m_pc_plus4,
  output logic                 L_S,
  output logic [4:0]           Wt_addr,
  output logic [31:0]          wt_data,
  output logic                 fwd_valid,
  output logic                 misalign_exc,
  output logic [INSTRET_W-1:0] instret
);
  logic                 r_valid;
  logic                 r_fresh;
  logic                 r_reg_write;
  logic [4:0]           r_rd;
  logic [31:0]          r_data;
  logic                 r_exc;
  logic [INSTRET_W-1:0] r_instret;
  logic [1:0]           w_off;
  logic                 w_is_b;
  logic                 w_is_h;
  logic                 w_is_w;
  logic                 w_uns;
  logic [31:0]          w_shifted;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_load;
  logic [31:0]          w_data;
  logic                 w_misalign;
  logic                 w_retire;
  logic                 w_wr_ok;

  // Load extraction/extension, write-back source mux and alignment check
  always_comb begin
    w_off      = m_alu_result[1:0];
    w_is_b     = (m_funct3 == 3'b000) || (m_funct3 == 3'b100);
    w_is_h     = (m_funct3 == 3'b001) || (m_funct3 == 3'b101);
    w_is_w     = !w_is_b && !w_is_h;
    w_uns      = m_funct3[2];
    w_shifted  = m_mem_rdata >> {w_off, 3'b000};
    w_byte     = w_shifted[7:0];
    w_half     = w_off[1] ? m_mem_rdata[31:16] : m_mem_rdata[15:0];
    w_load     = w_is_b ? {{24{!w_uns && w_byte[7]}}, w_byte} :
                 w_is_h ? {{16{!w_uns && w_half[15]}}, w_half} : m_mem_rdata;
    w_data     = (m_wb_sel == 2'b01) ? w_load :
                 (m_wb_sel == 2'b10) ? m_pc_plus4 : m_alu_result;
    w_misalign = (m_wb_sel == 2'b01) &&
                 ((w_is_h && w_off[0]) || (w_is_w && (w_off != 2'b00)));
    w_retire   = r_valid && r_fresh && !r_exc;
    w_wr_ok    = r_valid && r_reg_write && (r_rd != 5'd0) && !r_exc;
  end

  // Stage register: flush beats stall; a held entry is no longer fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_fresh     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= 5'd0;
      r_data      <= 32'd0;
      r_exc       <= 1'b0;
      r_instret   <= '0;
    end else begin
      r_instret <= r_instret + INSTRET_W'(w_retire);
      if (flush) begin
        r_valid <= 1'b0;
        r_fresh <= 1'b0;
      end else if (stall) begin
        r_fresh <= 1'b0;
      end else begin
        r_valid     <= m_valid;
        r_fresh     <= m_valid;
        r_reg_write <= m_reg_write;
        r_rd        <= m_rd;
        r_data      <= w_data;
        r_exc       <= w_misalign;
      end
    end
  end

  assign L_S          = w_wr_ok && r_fresh;
  assign Wt_addr      = r_rd;
  assign wt_data      = r_data;
  assign fwd_valid    = w_wr_ok;
  assign misalign_exc = r_valid && r_fresh && r_exc;
  assign instret      = r_instret;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vectors with a scoreboard checking register file writes
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_reg_write = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [1:0]  m_wb_sel = '0;
  logic [2:0]  m_funct3 = '0;
  logic [31:0] m_alu_result = '0;
  logic [31:0] m_mem_rdata = '0;
  logic [31:0] m_pc_plus4 = '0;
  logic        L_S;
  logic [4:0]  Wt_addr;
  logic [31:0] wt_data;
  logic        fwd_valid;
  logic        misalign_exc;
  logic [63:0] instret;
  logic        s_L_S;
  logic [4:0]  s_Wt_addr;
  logic [31:0] s_wt_data;
  logic        s_fwd_valid;
  logic        s_misalign_exc;
  logic [1:0]  s_instret;

  typedef struct {
    bit          exc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .m_valid(m_valid),
    .m_reg_write(m_reg_write), .m_rd(m_rd), .m_wb_sel(m_wb_sel), .m_funct3(m_funct3),
    .m_alu_result(m_alu_result), .m_mem_rdata(m_mem_rdata), .m_pc_plus4(m_pc_plus4),
    .L_S(L_S), .Wt_addr(Wt_addr), .wt_data(wt_data), .fwd_valid(fwd_valid),
    .misalign_exc(misalign_exc), .instret(instret)
  );

  mem_wb_stage #(.INSTRET_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .m_valid(m_valid),
    .m_reg_write(m_reg_write), .m_rd(m_rd), .m_wb_sel(m_wb_sel), .m_funct3(m_funct3),
    .m_alu_result(m_alu_result), .m_mem_rdata(m_mem_rdata), .m_pc_plus4(m_pc_plus4),
    .L_S(s_L_S), .Wt_addr(s_Wt_addr), .wt_data(s_wt_data), .fwd_valid(s_fwd_valid),
    .misalign_exc(s_misalign_exc), .instret(s_instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.exc = 1'b0;
    e.rd = rd;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic exp_exc(input logic [4:0] rd);
    exp_t e;
    e.exc = 1'b1;
    e.rd = rd;
    e.data = '0;
    q.push_back(e);
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc);
    m_valid = 1'b1;
    m_reg_write = 1'b1;
    m_rd = rd;
    m_wb_sel = sel;
    m_funct3 = f3;
    m_alu_result = alu;
    m_mem_rdata = rdata;
    m_pc_plus4 = pc;
    stall = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    m_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every write or exception the DUT presents must match the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (L_S || misalign_exc)) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output L_S=%b Wt_addr=%0d wt_data=%h misalign_exc=%b",
                   L_S, Wt_addr, wt_data, misalign_exc);
        end else begin
          e = q.pop_front();
          chk("sb_exc", {63'd0, misalign_exc}, {63'd0, e.exc});
          chk("sb_L_S", {63'd0, L_S}, {63'd0, !e.exc});
          chk("sb_Wt_addr", {59'd0, Wt_addr}, {59'd0, e.rd});
          if (!e.exc) chk("sb_wt_data", {32'd0, wt_data}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_L_S", {63'd0, L_S}, 64'd0);
    chk("rst_Wt_addr", {59'd0, Wt_addr}, 64'd0);
    chk("rst_wt_data", {32'd0, wt_data}, 64'd0);
    chk("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("rst_misalign", {63'd0, misalign_exc}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_wr(5'd5, 32'h1234_5678);
    issue(5'd5, 2'b00, 3'b010, 32'h1234_5678, 32'h0, 32'h0);
    idle(1);
    chk("instret_after_alu", instret, 64'd1);
    exp_wr(5'd1, 32'hFFFF_FF80);
    issue(5'd1, 2'b01, 3'b000, 32'h0000_0103, 32'h80FF_7F01, 32'h0);
    exp_wr(5'd2, 32'h0000_00FF);
    issue(5'd2, 2'b01, 3'b100, 32'h0000_0102, 32'h80FF_7F01, 32'h0);
    exp_wr(5'd3, 32'hFFFF_80FF);
    issue(5'd3, 2'b01, 3'b001, 32'h0000_0102, 32'h80FF_7F01, 32'h0);
    exp_wr(5'd4, 32'h0000_7F01);
    issue(5'd4, 2'b01, 3'b101, 32'h0000_0100, 32'h80FF_7F01, 32'h0);
    exp_wr(5'd6, 32'h80FF_7F01);
    issue(5'd6, 2'b01, 3'b111, 32'h0000_0104, 32'h80FF_7F01, 32'h0);
    exp_wr(5'd8, 32'h0000_2004);
    issue(5'd8, 2'b10, 3'b000, 32'h1111_1111, 32'h0, 32'h0000_2004);
    exp_wr(5'd8, 32'h3333_3333);
    issue(5'd8, 2'b11, 3'b000, 32'h3333_3333, 32'h0, 32'h0000_2008);
    idle(1);
    chk("instret_after_loads", instret, 64'd8);
    exp_exc(5'd7);
    issue(5'd7, 2'b01, 3'b010, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
    chk("misalign_lw_L_S", {63'd0, L_S}, 64'd0);
    chk("misalign_lw_fwd", {63'd0, fwd_valid}, 64'd0);
    exp_exc(5'd10);
    issue(5'd10, 2'b01, 3'b001, 32'h0000_0011, 32'h80FF_7F01, 32'h0);
    idle(1);
    chk("misalign_pulse_end", {63'd0, misalign_exc}, 64'd0);
    chk("instret_after_misalign", instret, 64'd8);
    exp_wr(5'd9, 32'hCAFE_F00D);
    issue(5'd9, 2'b00, 3'b000, 32'hCAFE_F00D, 32'h0, 32'h0);
    chk("stall_fwd_0", {63'd0, fwd_valid}, 64'd1);
    m_rd = 5'd11;
    m_alu_result = 32'hDEAD_BEEF;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_fwd_held", {63'd0, fwd_valid}, 64'd1);
      chk("stall_addr_held", {59'd0, Wt_addr}, 64'd9);
    end
    chk("stall_instret_once", instret, 64'd9);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_stall_fwd", {63'd0, fwd_valid}, 64'd0);
    chk("flush_instret", instret, 64'd9);
    issue(5'd0, 2'b00, 3'b000, 32'h0000_0055, 32'h0, 32'h0);
    chk("x0_L_S", {63'd0, L_S}, 64'd0);
    chk("x0_fwd", {63'd0, fwd_valid}, 64'd0);
    idle(1);
    chk("x0_instret", instret, 64'd10);
    exp_wr(5'd12, 32'h0000_0001);
    issue(5'd12, 2'b00, 3'b000, 32'h0000_0001, 32'h0, 32'h0);
    exp_wr(5'd12, 32'h0000_0002);
    issue(5'd12, 2'b00, 3'b000, 32'h0000_0002, 32'h0, 32'h0);
    idle(1);
    chk("b2b_instret", instret, 64'd12);
    exp_wr(5'd13, 32'h0000_ABCD);
    issue(5'd13, 2'b00, 3'b000, 32'h0000_ABCD, 32'h0, 32'h0);
    m_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_L_S", {63'd0, L_S}, 64'd0);
    chk("async_Wt_addr", {59'd0, Wt_addr}, 64'd0);
    chk("async_wt_data", {32'd0, wt_data}, 64'd0);
    chk("async_fwd", {63'd0, fwd_valid}, 64'd0);
    chk("async_misalign", {63'd0, misalign_exc}, 64'd0);
    chk("async_instret", instret, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_wr(5'd14, 32'(i));
      issue(5'd14, 2'b00, 3'b000, 32'(i), 32'h0, 32'h0);
    end
    idle(1);
    chk("small_instret_3", {62'd0, s_instret}, 64'd3);
    exp_wr(5'd15, 32'h0000_0077);
    issue(5'd15, 2'b00, 3'b000, 32'h0000_0077, 32'h0, 32'h0);
    idle(1);
    chk("small_instret_wrap", {62'd0, s_instret}, 64'd0);
    chk("instret_after_wrap", instret, 64'd4);
    idle(2);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
